// File: rtl/tea_cbc_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tea_cbc_ctrl                                               |
// | Description : Block-at-a-time controller wrapping an external TEA core.  |
// |               Adds ECB/CBC chaining, valid/ready streaming on the input  |
// |               and result side, a WAIT watchdog and sticky error flags.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk, reset_n           : clock (rising edge), async active-low reset   |
// |   key_load, key_in       : load 128-bit key (IDLE only)                  |
// |   iv_load, iv_in         : load 64-bit chain value, sample cfg_mode and  |
// |   cfg_mode, cfg_cbc      :   cfg_cbc (0/1 = encrypt/decrypt, ECB/CBC)    |
// |   s_valid/s_ready/s_data : input block stream                            |
// |   m_valid/m_ready/m_data : result stream                                 |
// |   core_in/key/mode/write : registered drive to the TEA core              |
// |   core_out(_ready)       : TEA core result                               |
// |   busy                   : state is not IDLE                             |
// |   err_cmd, err_timeout   : sticky error flags (cleared by reset only)    |
// |   blk_count              : completed result handshakes, wraps at 16 bit  |
// +--------------------------------------------------------------------------+
module tea_cbc_ctrl #(
  parameter int ROUNDS  = 32,
  parameter int TIMEOUT = ROUNDS + 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         key_load,
  input  logic [127:0] key_in,
  input  logic         iv_load,
  input  logic [63:0]  iv_in,
  input  logic         cfg_mode,
  input  logic         cfg_cbc,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [63:0]  s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [63:0]  m_data,
  output logic [63:0]  core_in,
  output logic [127:0] core_key,
  output logic         core_mode,
  output logic         core_write,
  input  logic [63:0]  core_out,
  input  logic         core_out_ready,
  output logic         busy,
  output logic         err_cmd,
  output logic         err_timeout,
  output logic [15:0]  blk_count
);

  // WAIT counter covers 0 .. TIMEOUT-1
  localparam int              c_TW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(TIMEOUT - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_WRITE = 2'd1;
  localparam logic [1:0] c_WAIT  = 2'd2;
  localparam logic [1:0] c_OUT   = 2'd3;

  logic [1:0]      state_q, state_d;

  logic [127:0]    key_q, key_d;
  logic            key_valid_q, key_valid_d;
  logic [63:0]     chain_q, chain_d;
  logic            mode_q, mode_d;
  logic            cbc_q, cbc_d;
  logic [63:0]     blk_q, blk_d;
  logic [63:0]     core_in_q, core_in_d;
  logic [127:0]    core_key_q, core_key_d;
  logic            core_mode_q, core_mode_d;
  logic [63:0]     m_data_q, m_data_d;
  logic [c_TW-1:0] wait_cnt_q, wait_cnt_d;
  logic [15:0]     blk_count_q, blk_count_d;
  logic            err_cmd_q, err_cmd_d;
  logic            err_timeout_q, err_timeout_d;

  logic            w_s_ready;
  logic            w_accept;
  logic            w_core_done;
  logic            w_timeout;
  logic            w_leave_wait;
  logic            w_m_fire;

  // Any config load in the same cycle blocks acceptance so the new key/IV
  // is guaranteed to be in place for the block that follows it.
  assign w_s_ready    = (state_q == c_IDLE) && key_valid_q && !key_load && !iv_load;
  assign w_accept     = s_valid && w_s_ready;
  // core_out_ready is only meaningful in WAIT; during WRITE it still
  // reflects the previous block.
  assign w_core_done  = (state_q == c_WAIT) && core_out_ready;
  assign w_timeout    = (state_q == c_WAIT) && !core_out_ready && (wait_cnt_q == c_TO_LAST);
  assign w_leave_wait = w_core_done || w_timeout;
  assign w_m_fire     = (state_q == c_OUT) && m_ready;

  // ---------------------------------------------------------------- FSM --
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (w_accept)     state_d = c_WRITE;
      c_WRITE:                   state_d = c_WAIT;
      c_WAIT:  if (w_leave_wait) state_d = c_OUT;
      c_OUT:   if (m_ready)      state_d = c_IDLE;
      default:                   state_d = c_IDLE;
    endcase
  end

  always_comb begin
    s_ready    = w_s_ready;
    m_valid    = (state_q == c_OUT);
    core_write = (state_q == c_WRITE);
    busy       = (state_q != c_IDLE);
  end

  // ----------------------------------------------------------- datapath --
  always_comb begin
    key_d         = key_q;
    key_valid_d   = key_valid_q;
    chain_d       = chain_q;
    mode_d        = mode_q;
    cbc_d         = cbc_q;
    blk_d         = blk_q;
    core_in_d     = core_in_q;
    core_key_d    = core_key_q;
    core_mode_d   = core_mode_q;
    m_data_d      = m_data_q;
    wait_cnt_d    = wait_cnt_q;
    blk_count_d   = blk_count_q;
    err_cmd_d     = err_cmd_q;
    err_timeout_d = err_timeout_q;

    // Configuration: honoured in IDLE, flagged and dropped elsewhere.
    if (state_q == c_IDLE) begin
      if (key_load) begin
        key_d       = key_in;
        key_valid_d = 1'b1;
      end
      if (iv_load) begin
        chain_d = iv_in;
        mode_d  = cfg_mode;
        cbc_d   = cfg_cbc;
      end
    end else if (key_load || iv_load) begin
      err_cmd_d = 1'b1;
    end

    // Snapshot everything the core needs so it stays stable through WAIT.
    if (w_accept) begin
      blk_d       = s_data;
      core_in_d   = (!mode_q && cbc_q) ? (s_data ^ chain_q) : s_data;
      core_key_d  = key_q;
      core_mode_d = mode_q;
      wait_cnt_d  = '0;
    end

    if ((state_q == c_WAIT) && !w_leave_wait) begin
      wait_cnt_d = wait_cnt_q + c_TW'(1);
    end

    if (w_core_done) begin
      m_data_d = (mode_q && cbc_q) ? (core_out ^ chain_q) : core_out;
    end

    if (w_timeout) begin
      m_data_d      = '0;
      err_timeout_d = 1'b1;
    end

    // Encrypt chains on ciphertext (core output); decrypt chains on the
    // ciphertext that was fed in (held in blk).
    if (w_leave_wait && cbc_q) begin
      chain_d = mode_q ? blk_q : core_out;
    end

    if (w_m_fire) begin
      blk_count_d = blk_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q         <= '0;
      key_valid_q   <= 1'b0;
      chain_q       <= '0;
      mode_q        <= 1'b0;
      cbc_q         <= 1'b0;
      blk_q         <= '0;
      core_in_q     <= '0;
      core_key_q    <= '0;
      core_mode_q   <= 1'b0;
      m_data_q      <= '0;
      wait_cnt_q    <= '0;
      blk_count_q   <= '0;
      err_cmd_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      key_q         <= key_d;
      key_valid_q   <= key_valid_d;
      chain_q       <= chain_d;
      mode_q        <= mode_d;
      cbc_q         <= cbc_d;
      blk_q         <= blk_d;
      core_in_q     <= core_in_d;
      core_key_q    <= core_key_d;
      core_mode_q   <= core_mode_d;
      m_data_q      <= m_data_d;
      wait_cnt_q    <= wait_cnt_d;
      blk_count_q   <= blk_count_d;
      err_cmd_q     <= err_cmd_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign m_data      = m_data_q;
  assign core_in     = core_in_q;
  assign core_key    = core_key_q;
  assign core_mode   = core_mode_q;
  assign blk_count   = blk_count_q;
  assign err_cmd     = err_cmd_q;
  assign err_timeout = err_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_tea_cbc_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_tea_cbc_ctrl                                            |
// | Description : Directed self-checking bench for tea_cbc_ctrl with a       |
// |               behavioural TEA core attached.                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_tea_cbc_ctrl;

  localparam int ROUNDS  = 32;
  localparam int TIMEOUT = ROUNDS + 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         key_load = 1'b0;
  logic [127:0] key_in = '0;
  logic         iv_load = 1'b0;
  logic [63:0]  iv_in = '0;
  logic         cfg_mode = 1'b0;
  logic         cfg_cbc = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [63:0]  s_data = '0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [63:0]  m_data;
  logic [63:0]  core_in;
  logic [127:0] core_key;
  logic         core_mode;
  logic         core_write;
  logic [63:0]  core_out;
  logic         core_out_ready;
  logic         busy;
  logic         err_cmd;
  logic         err_timeout;
  logic [15:0]  blk_count;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  tea_cbc_ctrl #(.ROUNDS(ROUNDS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .key_load(key_load), .key_in(key_in),
    .iv_load(iv_load), .iv_in(iv_in), .cfg_mode(cfg_mode), .cfg_cbc(cfg_cbc),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .core_in(core_in), .core_key(core_key), .core_mode(core_mode), .core_write(core_write),
    .core_out(core_out), .core_out_ready(core_out_ready),
    .busy(busy), .err_cmd(err_cmd), .err_timeout(err_timeout), .blk_count(blk_count)
  );

  // ---------------------------------------------------- reference TEA ----
  function automatic logic [63:0] tea_enc(input logic [63:0] d, input logic [127:0] k);
    logic [31:0] v0, v1, sum;
    v0 = d[63:32]; v1 = d[31:0]; sum = 32'd0;
    for (int i = 0; i < ROUNDS; i++) begin
      sum = sum + 32'h9E3779B9;
      v0  = v0 + (((v1 << 4) + k[127:96]) ^ (v1 + sum) ^ ((v1 >> 5) + k[95:64]));
      v1  = v1 + (((v0 << 4) + k[63:32]) ^ (v0 + sum) ^ ((v0 >> 5) + k[31:0]));
    end
    return {v0, v1};
  endfunction

  function automatic logic [63:0] tea_dec(input logic [63:0] d, input logic [127:0] k);
    logic [31:0] v0, v1, sum;
    v0 = d[63:32]; v1 = d[31:0]; sum = 32'd0;
    for (int i = 0; i < ROUNDS; i++) sum = sum + 32'h9E3779B9;
    for (int i = 0; i < ROUNDS; i++) begin
      v1  = v1 - (((v0 << 4) + k[63:32]) ^ (v0 + sum) ^ ((v0 >> 5) + k[31:0]));
      v0  = v0 - (((v1 << 4) + k[127:96]) ^ (v1 + sum) ^ ((v1 >> 5) + k[95:64]));
      sum = sum - 32'h9E3779B9;
    end
    return {v0, v1};
  endfunction

  // Core model: captures on core_write, raises ready ROUNDS+1 edges later
  // and leaves it (stale) high until the next write. core_stall suppresses it.
  logic [63:0] core_res = '0;
  logic        core_rdy = 1'b0;
  logic        core_stall = 1'b0;
  int          core_cnt = 0;

  always @(posedge clk) begin
    if (core_write) begin
      core_res <= core_mode ? tea_dec(core_in, core_key) : tea_enc(core_in, core_key);
      core_cnt <= ROUNDS + 1;
      core_rdy <= 1'b0;
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1 && !core_stall) core_rdy <= 1'b1;
    end
  end

  assign core_out       = core_res;
  assign core_out_ready = core_rdy;

  // ---------------------------------------------------------- helpers ----
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    key_in = k; key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  task automatic load_iv(input logic [63:0] iv, input logic mode, input logic cbc);
    iv_in = iv; cfg_mode = mode; cfg_cbc = cbc; iv_load = 1'b1;
    tick();
    iv_load = 1'b0;
  endtask

  // Returns just after the handshake edge.
  task automatic start_block(input logic [63:0] d);
    int n;
    n = 0;
    s_data = d; s_valid = 1'b1;
    #1;
    while (!s_ready && n < 50) begin tick(); n++; end
    chk("s_accept", 128'(s_ready), 128'd1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output int cw);
    lat = 0;
    cw  = int'(core_write);
    while (!m_valid && lat < 100) begin
      tick();
      lat++;
      cw += int'(core_write);
    end
    chk("m_valid_seen", 128'(m_valid), 128'd1);
  endtask

  task automatic take_out(output logic [63:0] res);
    res = m_data;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic chk_reset_outs(input string pfx);
    chk({pfx, "_s_ready"},     128'(s_ready),     128'd0);
    chk({pfx, "_m_valid"},     128'(m_valid),     128'd0);
    chk({pfx, "_core_write"},  128'(core_write),  128'd0);
    chk({pfx, "_busy"},        128'(busy),        128'd0);
    chk({pfx, "_err_cmd"},     128'(err_cmd),     128'd0);
    chk({pfx, "_err_timeout"}, 128'(err_timeout), 128'd0);
    chk({pfx, "_blk_count"},   128'(blk_count),   128'd0);
    chk({pfx, "_m_data"},      128'(m_data),      128'd0);
    chk({pfx, "_core_in"},     128'(core_in),     128'd0);
    chk({pfx, "_core_key"},    core_key,          128'd0);
    chk({pfx, "_core_mode"},   128'(core_mode),   128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------- stimulus ---
  localparam logic [127:0] K  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] K2 = 128'hFFFFFFFF000000005555555533333333;
  localparam logic [63:0]  IV = 64'h0123456789ABCDEF;

  logic [63:0] pt [3];
  logic [63:0] ct [3];
  logic [63:0] res, exp_d, chain;
  int          lat, cw;

  initial begin
    pt[0] = 64'h0000000000000000;
    pt[1] = 64'hDEADBEEFCAFEBABE;
    pt[2] = 64'h1122334455667788;

    // Power-on reset
    repeat (3) tick();
    chk_reset_outs("por");
    #2 reset_n = 1'b1;
    tick();
    chk("s_ready_nokey", 128'(s_ready), 128'd0);

    // ECB encrypt, key 0, data 0, with latency and single core_write
    load_key(128'd0);
    #1;
    chk("s_ready_keyed", 128'(s_ready), 128'd1);
    iv_load = 1'b1; #1;
    chk("s_ready_ivload", 128'(s_ready), 128'd0);
    iv_load = 1'b0;
    start_block(64'd0);
    chk("busy_write", 128'(busy), 128'd1);
    chk("core_write_hi", 128'(core_write), 128'd1);
    wait_out(lat, cw);
    chk("ecb_latency", 128'(lat), 128'd35);
    chk("core_write_once", 128'(cw), 128'd1);
    take_out(res);
    chk("ecb_enc", 128'(res), 128'h41EA3A0A94BAA940);
    chk("blk_count_1", 128'(blk_count), 128'd1);

    // ECB decrypt
    load_iv(64'd0, 1'b1, 1'b0);
    start_block(64'h41EA3A0A94BAA940);
    wait_out(lat, cw);
    take_out(res);
    chk("ecb_dec", 128'(res), 128'd0);

    // Reset pulse between blocks (asynchronous assertion)
    reset_n = 1'b0; #1;
    chk("rst_blk_count", 128'(blk_count), 128'd0);
    tick();
    #2 reset_n = 1'b1;
    tick();

    // CBC round trip
    load_key(K);
    load_iv(IV, 1'b0, 1'b1);
    chain = IV;
    for (int i = 0; i < 3; i++) begin
      start_block(pt[i]);
      wait_out(lat, cw);
      take_out(res);
      exp_d = tea_enc(pt[i] ^ chain, K);
      chk($sformatf("cbc_enc%0d", i), 128'(res), 128'(exp_d));
      ct[i] = res;
      chain = exp_d;
    end
    load_iv(IV, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      start_block(ct[i]);
      wait_out(lat, cw);
      take_out(res);
      chk($sformatf("cbc_dec%0d", i), 128'(res), 128'(pt[i]));
    end
    chk("cbc_blk_count", 128'(blk_count), 128'd6);

    // Backpressure in OUT
    load_iv(64'd0, 1'b0, 1'b0);
    start_block(64'hA5A5A5A55A5A5A5A);
    wait_out(lat, cw);
    exp_d = tea_enc(64'hA5A5A5A55A5A5A5A, K);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_m_data%0d", i), 128'(m_data), 128'(exp_d));
      tick();
    end
    chk("bp_s_ready", 128'(s_ready), 128'd0);
    chk("bp_m_valid", 128'(m_valid), 128'd1);
    take_out(res);

    // key_load during WAIT: flagged and ignored
    chk("err_cmd_before", 128'(err_cmd), 128'd0);
    start_block(64'h0F0F0F0F0F0F0F0F);
    tick(); tick();
    key_in = K2; key_load = 1'b1;
    tick();
    key_load = 1'b0; key_in = K;
    chk("err_cmd_set", 128'(err_cmd), 128'd1);
    wait_out(lat, cw);
    take_out(res);
    chk("key_kept_a", 128'(res), 128'(tea_enc(64'h0F0F0F0F0F0F0F0F, K)));
    start_block(64'h0123012301230123);
    wait_out(lat, cw);
    take_out(res);
    chk("key_kept_b", 128'(res), 128'(tea_enc(64'h0123012301230123, K)));

    // Timeout with core stalled
    core_stall = 1'b1;
    start_block(64'h7777777777777777);
    chk("err_timeout_before", 128'(err_timeout), 128'd0);
    wait_out(lat, cw);
    chk("timeout_latency", 128'(lat), 128'(TIMEOUT + 1));
    chk("err_timeout_set", 128'(err_timeout), 128'd1);
    chk("timeout_m_data", 128'(m_data), 128'd0);
    take_out(res);
    core_stall = 1'b0;

    // Reset in the middle of WAIT
    start_block(64'h1234567812345678);
    tick(); tick(); tick();
    chk("mid_busy_pre", 128'(busy), 128'd1);
    reset_n = 1'b0; #1;
    chk_reset_outs("mid");
    tick();
    #2 reset_n = 1'b1;
    repeat (40) tick();
    chk("mid_no_emit", 128'(m_valid), 128'd0);
    chk("mid_s_ready_nokey", 128'(s_ready), 128'd0);
    load_key(K);
    #1;
    chk("mid_s_ready_keyed", 128'(s_ready), 128'd1);
    start_block(64'd0);
    wait_out(lat, cw);
    take_out(res);
    chk("post_reset_ecb", 128'(res), 128'(tea_enc(64'd0, K)));

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
`default_nettype wire
